// File: rtl/bsg_manycore_sdr_reset_sequencer.sv
// bsg_manycore_sdr_reset_sequencer: ordered release of the four SDR link resets with a programmable per-phase hold
module bsg_manycore_sdr_reset_sequencer #(
  parameter int hold_cycles_p = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic async_uplink_reset_o,
  output logic async_downlink_reset_o,
  output logic async_downstream_reset_o,
  output logic async_token_reset_o,
  output logic done_o
);
  localparam int ctr_width_lp = hold_cycles_p > 1 ? $clog2(hold_cycles_p) : 1;
  localparam logic [ctr_width_lp-1:0] last_lp = ctr_width_lp'(hold_cycles_p - 1);
  typedef enum logic [2:0] {S_ALL, S_TOK, S_TOK_REL, S_UP_REL, S_DOWN_REL, S_DONE} state_e;
  state_e state_r, state_n;
  logic [ctr_width_lp-1:0] ctr_r, ctr_n;
  logic last;
  // next state: restart wins over the terminal-count advance; done is sticky
  always_comb begin
    last = ctr_r == last_lp;
    state_n = start_i ? S_ALL
            : state_r == S_DONE ? S_DONE
            : last ? state_e'(state_r + 3'd1)
            : state_r;
    ctr_n = (start_i || last || state_r == S_DONE) ? '0 : ctr_r + ctr_width_lp'(1);
  end
  // state, counter and outputs share one edge; outputs decode the next state so ports see only flops
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_r <= S_ALL;
      ctr_r <= '0;
      async_uplink_reset_o <= 1'b1;
      async_downlink_reset_o <= 1'b1;
      async_downstream_reset_o <= 1'b1;
      async_token_reset_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state_r <= state_n;
      ctr_r <= ctr_n;
      async_uplink_reset_o <= state_n == S_ALL || state_n == S_TOK || state_n == S_TOK_REL;
      async_downlink_reset_o <= state_n != S_DOWN_REL && state_n != S_DONE;
      async_downstream_reset_o <= state_n != S_DONE;
      async_token_reset_o <= state_n == S_TOK;
      done_o <= state_n == S_DONE;
    end
endmodule

// File: tb/tb_bsg_manycore_sdr_reset_sequencer.sv
// tb_bsg_manycore_sdr_reset_sequencer: directed vectors for H=4 and H=1 sequencers
module tb_bsg_manycore_sdr_reset_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic up, down, ds, tok, done;
  logic up1, down1, ds1, tok1, done1;
  logic [4:0] o4, o1;
  int checks = 0;
  int fails = 0;

  typedef struct {int e; logic [4:0] exp;} vec_t;
  vec_t tbl4[12];
  logic [4:0] tbl1[6];

  always #5 clk = ~clk;

  assign o4 = {up, down, ds, tok, done};
  assign o1 = {up1, down1, ds1, tok1, done1};

  bsg_manycore_sdr_reset_sequencer #(.hold_cycles_p(4)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start),
    .async_uplink_reset_o(up), .async_downlink_reset_o(down),
    .async_downstream_reset_o(ds), .async_token_reset_o(tok), .done_o(done)
  );

  bsg_manycore_sdr_reset_sequencer #(.hold_cycles_p(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .start_i(start1),
    .async_uplink_reset_o(up1), .async_downlink_reset_o(down1),
    .async_downstream_reset_o(ds1), .async_token_reset_o(tok1), .done_o(done1)
  );

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {up,down,ds,tok,done}=%b, required %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int k;
    tbl4[0]  = '{1,  5'b11100};
    tbl4[1]  = '{3,  5'b11100};
    tbl4[2]  = '{4,  5'b11110};
    tbl4[3]  = '{7,  5'b11110};
    tbl4[4]  = '{8,  5'b11100};
    tbl4[5]  = '{11, 5'b11100};
    tbl4[6]  = '{12, 5'b01100};
    tbl4[7]  = '{15, 5'b01100};
    tbl4[8]  = '{16, 5'b00100};
    tbl4[9]  = '{19, 5'b00100};
    tbl4[10] = '{20, 5'b00001};
    tbl4[11] = '{70, 5'b00001};
    tbl1 = '{5'b11110, 5'b11100, 5'b01100, 5'b00100, 5'b00001, 5'b00001};

    #12;
    check("reset_h4", o4, 5'b11100);
    check("reset_h1", o1, 5'b11100);
    @(negedge clk);
    rst = 1'b0;

    k = 0;
    for (int e = 1; e <= 70; e++) begin
      step(1);
      if (k < 12 && tbl4[k].e == e) begin
        check($sformatf("basic_e%0d", e), o4, tbl4[k].exp);
        k++;
      end
      if (e <= 6) check($sformatf("minhold_e%0d", e), o1, tbl1[e-1]);
      if (e > 20 && e < 70 && o4 !== 5'b00001) check($sformatf("done_stable_e%0d", e), o4, 5'b00001);
    end

    start = 1'b1;
    step(1);
    check("restart_done_k", o4, 5'b11100);
    start = 1'b0;
    step(4);
    check("restart_done_k4", o4, 5'b11110);
    step(15);
    check("restart_done_k19", o4, 5'b00100);
    step(1);
    check("restart_done_k20", o4, 5'b00001);

    start = 1'b1;
    step(1);
    start = 1'b0;
    step(12);
    check("mid_e12", o4, 5'b01100);
    start = 1'b1;
    step(1);
    check("mid_e13", o4, 5'b11100);
    start = 1'b0;
    step(3);
    check("mid_e16", o4, 5'b11100);
    step(1);
    check("mid_e17", o4, 5'b11110);
    step(15);
    check("mid_e32", o4, 5'b00100);
    step(1);
    check("mid_e33", o4, 5'b00001);

    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("held_%0d", i), o4, 5'b11100);
    end
    start = 1'b0;
    step(3);
    check("held_rel3", o4, 5'b11100);
    step(1);
    check("held_rel4", o4, 5'b11110);
    step(12);
    check("held_rel16", o4, 5'b00100);
    #2;
    rst = 1'b1;
    #1;
    check("async_mid", o4, 5'b11100);
    check("async_mid_h1", o1, 5'b11100);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    check("rerun_e3", o4, 5'b11100);
    step(1);
    check("rerun_e4", o4, 5'b11110);
    step(15);
    check("rerun_e19", o4, 5'b00100);
    step(1);
    check("rerun_e20", o4, 5'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
